frame_packer: RTL
=================

// Module: frame_packer
// PURPOSE
//  Upstream framing stage feeding dut_top: collects raw payload bytes, buffers complete frames, emits
//  each frame as a BND-marked length header followed by PLSE-strobed payload bytes. Rejects over-long
//  or overflowing frames atomically, so the downstream block only ever sees whole, legal frames.
// PARAMETERS
//  MAX_PAYLOAD  64   max payload bytes per frame (1..255); longer frames dropped
//  DATA_DEPTH   128  payload byte buffer entries (power of 2, >= MAX_PAYLOAD)
//  LEN_DEPTH    4    committed-frame length queue entries (power of 2)
// PORTS
//  clk        in   1  clock, rising edge
//  reset      in   1  asynchronous, active-high reset
//  in_valid   in   1  in_data valid this cycle (no backpressure; source cannot stall)
//  in_data    in   8  payload byte
//  in_last    in   1  with in_valid: final byte of frame
//  out_stall  in   1  downstream hold request; all outputs freeze while high
//  bnd        out  1  frame boundary: high for the header cycle only
//  plse       out  1  payload byte strobe
//  data_out   out  8  header length / payload / checksum byte
//  len_err    out  1  1-cycle pulse: frame dropped, length > MAX_PAYLOAD
//  ovf_err    out  1  1-cycle pulse: frame dropped, data or length buffer full
//  frames_sent out 16 wrapping count of frames fully emitted
// BEHAVIOUR
//  Reset: all outputs 0, buffers empty, FSM IDLE, frame_start_ptr = wr_ptr = 0; reset mid-frame
//   abandons both input and output frames with no further strobes.
//  Write side: byte written at wr_ptr when in_valid and not dropping; byte_cnt++ (8 bit, saturating).
//   in_last accepted at edge N: length = byte_cnt+1 pushed to length queue, frame_start_ptr <= wr_ptr+1.
//   Data full or length-queue full at in_last: wr_ptr <= frame_start_ptr (rollback), ovf_err pulses at
//   N+1, drop mode until in_last inclusive. byte_cnt reaching MAX_PAYLOAD with no in_last: rollback,
//   len_err at N+1, drop mode. Exactly MAX_PAYLOAD bytes is legal. Single-byte frame (valid+last) legal.
//   Buffer space counts from rd_ptr; committed frames are never overwritten.
//  Read FSM: IDLE -> HDR when length queue non-empty and !out_stall. HDR: bnd=1, data_out=length.
//   -> PAY for `length` cycles: plse=1, data_out=payload byte, rd_ptr++. Last byte -> CSUM (if enabled)
//   else IDLE; frames_sent++ on exit. IDLE->HDR back-to-back allowed: no gap cycle between frames.
//  Latency: in_last accepted at edge N -> bnd high in cycle after edge N+2 (empty, unstalled packer).
//  Outputs registered; bnd and plse never both high; data_out = 0 when bnd=plse=0.
//  out_stall: FSM, pointers, outputs hold exact values; write side continues unaffected.
//  Simultaneous in_last commit and read-side pop: both occur; queue counts net correctly.
//  All pointers wrap modulo depth; one extra MSB distinguishes full from empty.
// CONFIGURATION
//  FRAME_CSUM_EN defined: after last payload byte one CSUM cycle, plse=1, data_out = XOR of length and
//   all payload bytes. Undefined: no CSUM state; frame ends on last payload byte.
// STRUCTURE
//  frame_pkg: typedef enum {IDLE, HDR, PAY, CSUM} pk_state_e; byte_t; MAX_PAYLOAD_DEF, HDR_BYTES.
//  Sub-module frame_sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/count, plus wr_ptr
//   load port for rollback), instantiated twice: payload bytes (8b) and lengths (8b).
// TESTING
//  Sanity: frame 3 bytes A1,B2,C3 -> bnd with 03, plse A1,B2,C3 (+CSUM 03^A1^B2^C3=D3), frames_sent=1.
//  MAX payload: 64 bytes 00..3F -> header 40, 64 plse; 65 bytes -> len_err once, nothing emitted.
//  MIN payload: 1-byte frame 5A -> header 01, one plse 5A; back-to-back with next frame, no idle gap.
//  Overflow: out_stall=1, push 4 frames of 40 bytes (DATA_DEPTH=128) -> 4th gets ovf_err, release
//   stall -> first 3 frames emitted intact, 4th absent.
//  Stall: assert out_stall mid-payload 5 cycles -> data_out/plse frozen, resumes with next byte.
//  Reset mid-frame at payload byte 10 -> all outputs 0 next cycle, empty, next frame emits cleanly.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared types and constants for the frame packer slice.
package frame_pkg;

    typedef enum logic [1:0] {IDLE, HDR, PAY, CSUM} pk_state_e;

    typedef logic [7:0] byte_t;

    localparam int MAX_PAYLOAD_DEF = 64;
    localparam int HDR_BYTES       = 1;

    function automatic byte_t csum_step(input byte_t acc, input byte_t b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/frame_sync_fifo.sv
// Synchronous FIFO with an extra pointer MSB for full/empty and a write-pointer
// load port so a partially written frame can be rolled back.
module frame_sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    input  logic             wr_load,
    input  logic [AW:0]      wr_load_ptr,
    output logic [AW:0]      wr_ptr,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !full && !wr_load) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // A rollback load wins over a push issued in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_load) begin
                wr_ptr <= wr_load_ptr;
            end else if (push && !full) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign count    = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/frame_packer.sv
// frame_packer: buffers raw bytes into whole frames, emits header + payload beats.
// Define FRAME_CSUM_EN to append an XOR checksum beat after each payload.
module frame_packer
    import frame_pkg::*;
#(
    parameter int MAX_PAYLOAD = MAX_PAYLOAD_DEF,
    parameter int DATA_DEPTH  = 128,
    parameter int LEN_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    input  logic        out_stall,
    output logic        bnd,
    output logic        plse,
    output logic [7:0]  data_out,
    output logic        len_err,
    output logic        ovf_err,
    output logic [15:0] frames_sent
);

    localparam int          DAW       = $clog2(DATA_DEPTH);
    localparam int          LAW       = $clog2(LEN_DEPTH);
    localparam logic [DAW:0] DPTR_ONE = 1;
    localparam byte_t       LAST_SLOT = byte_t'(MAX_PAYLOAD - 1);
    localparam logic [8:0]  HDR_BEATS = 9'(HDR_BYTES);

    logic           data_push, data_full, data_empty, wr_load;
    logic [DAW:0]   data_wr_ptr, data_cnt, frame_start_ptr;
    byte_t          rd_data;
    logic           len_push, len_full, len_empty;
    logic [LAW:0]   len_wr_ptr, len_cnt;
    byte_t          len_head;
    logic           dropping, ovf_now, len_now;
    byte_t          byte_cnt;
    logic           frame_end, take_next, data_pop;
    pk_state_e      state;
    byte_t          cur_len;
    logic [8:0]     rem;
`ifdef FRAME_CSUM_EN
    byte_t          csum;
`endif
    logic           unused_status;

    frame_sync_fifo #(.WIDTH(8), .DEPTH(DATA_DEPTH)) u_data_fifo (
        .clk(clk), .reset(reset),
        .push(data_push), .push_data(in_data),
        .pop(data_pop), .pop_data(rd_data),
        .wr_load(wr_load), .wr_load_ptr(frame_start_ptr), .wr_ptr(data_wr_ptr),
        .full(data_full), .empty(data_empty), .count(data_cnt)
    );

    frame_sync_fifo #(.WIDTH(8), .DEPTH(LEN_DEPTH)) u_len_fifo (
        .clk(clk), .reset(reset),
        .push(len_push), .push_data(byte_cnt + 8'd1),
        .pop(take_next), .pop_data(len_head),
        .wr_load(1'b0), .wr_load_ptr('0), .wr_ptr(len_wr_ptr),
        .full(len_full), .empty(len_empty), .count(len_cnt)
    );

    assign unused_status = ^{data_empty, data_cnt, len_cnt, len_wr_ptr};

    // A byte arriving on a full buffer, or a frame still open at MAX_PAYLOAD bytes, is dropped whole.
    always_comb begin
        data_push = 1'b0;
        len_push  = 1'b0;
        wr_load   = 1'b0;
        ovf_now   = 1'b0;
        len_now   = 1'b0;
        if (in_valid && !dropping) begin
            if (data_full || (in_last && len_full)) begin
                ovf_now = 1'b1;
                wr_load = 1'b1;
            end else if (!in_last && byte_cnt == LAST_SLOT) begin
                len_now = 1'b1;
                wr_load = 1'b1;
            end else begin
                data_push = 1'b1;
                len_push  = in_last;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dropping        <= 1'b0;
            byte_cnt        <= '0;
            frame_start_ptr <= '0;
            len_err         <= 1'b0;
            ovf_err         <= 1'b0;
        end else begin
            len_err <= len_now;
            ovf_err <= ovf_now;
            if (in_valid) begin
                if (dropping) begin
                    if (in_last) begin
                        dropping <= 1'b0;
                    end
                end else if (ovf_now || len_now) begin
                    dropping <= !in_last;
                    byte_cnt <= '0;
                end else if (in_last) begin
                    byte_cnt        <= '0;
                    frame_start_ptr <= data_wr_ptr + DPTR_ONE;
                end else if (byte_cnt != 8'hFF) begin
                    byte_cnt <= byte_cnt + 8'd1;
                end
            end
        end
    end

    always_comb begin
        frame_end = 1'b0;
`ifdef FRAME_CSUM_EN
        frame_end = (state == CSUM);
`else
        frame_end = (state == PAY) && (rem == 9'd1);
`endif
        take_next = !out_stall && !len_empty && ((state == IDLE) || frame_end);
        data_pop  = !out_stall && (state == PAY);
    end

    // rem counts beats still to emit for the current frame (header included).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bnd         <= 1'b0;
            plse        <= 1'b0;
            data_out    <= '0;
            frames_sent <= '0;
            cur_len     <= '0;
            rem         <= '0;
`ifdef FRAME_CSUM_EN
            csum        <= '0;
`endif
        end else if (!out_stall) begin
            case (state)
                IDLE: begin
                    bnd      <= 1'b0;
                    plse     <= 1'b0;
                    data_out <= '0;
                end
                HDR: begin
                    bnd      <= 1'b1;
                    plse     <= 1'b0;
                    data_out <= cur_len;
                    rem      <= rem - 9'd1;
                    state    <= PAY;
`ifdef FRAME_CSUM_EN
                    csum     <= cur_len;
`endif
                end
                PAY: begin
                    bnd      <= 1'b0;
                    plse     <= 1'b1;
                    data_out <= rd_data;
                    rem      <= rem - 9'd1;
`ifdef FRAME_CSUM_EN
                    csum     <= csum_step(csum, rd_data);
                    if (rem == 9'd1) begin
                        state <= CSUM;
                    end
`else
                    if (rem == 9'd1) begin
                        state       <= IDLE;
                        frames_sent <= frames_sent + 16'd1;
                    end
`endif
                end
`ifdef FRAME_CSUM_EN
                CSUM: begin
                    bnd         <= 1'b0;
                    plse        <= 1'b1;
                    data_out    <= csum;
                    frames_sent <= frames_sent + 16'd1;
                    state       <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
            if (take_next) begin
                state   <= HDR;
                cur_len <= len_head;
                rem     <= {1'b0, len_head} + HDR_BEATS;
            end
        end
    end

endmodule
